// File: rtl/move_selector_if.sv
// move_selector_if: bundle of the per-node handshake and result signals
// between the move evaluator / search controller side and move_selector.
//   master : upstream side; drives start_in, beta_in, move_in, eval_in,
//            valid_in, done_in and observes the result outputs.
//   slave  : move_selector side; the mirror image.
// MOVE_W is the width of move_t; CNT_W is the legal-move counter width.
interface move_selector_if #(
  parameter int CNT_W  = 8,
  parameter int MOVE_W = 16
);
  logic                start_in;
  logic signed [15:0]  beta_in;
  logic [MOVE_W-1:0]   move_in;
  logic signed [15:0]  eval_in;
  logic                valid_in;
  logic                done_in;

  logic                abort_out;
  logic                done_out;
  logic                busy_out;
  logic [MOVE_W-1:0]   best_move_out;
  logic signed [15:0]  best_eval_out;
  logic [CNT_W-1:0]    legal_cnt_out;
  logic                cutoff_out;
  logic                no_legal_out;

  modport master (
    output start_in, beta_in, move_in, eval_in, valid_in, done_in,
    input  abort_out, done_out, busy_out, best_move_out, best_eval_out,
           legal_cnt_out, cutoff_out, no_legal_out
  );

  modport slave (
    input  start_in, beta_in, move_in, eval_in, valid_in, done_in,
    output abort_out, done_out, busy_out, best_move_out, best_eval_out,
           legal_cnt_out, cutoff_out, no_legal_out
  );
endinterface

// File: rtl/move_selector.sv
// move_selector: reduces the stream of scored moves for one search node to
// the best move, its eval and the legal-move count, and performs the
// alpha-beta fail-high test (abort pulse to the move generator).
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset
//   bus     : move_selector_if.slave (inputs from evaluator/controller,
//             result outputs held stable after the one-cycle done_out pulse)
module move_selector #(
  parameter int CNT_W  = 8,
  parameter int MOVE_W = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  move_selector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic signed [15:0] EVAL_MIN = 16'sh8000;

  state_t              state_q, state_d;
  logic signed [15:0]  beta_q, beta_d;
  logic signed [15:0]  best_eval_q, best_eval_d;
  logic [MOVE_W-1:0]   best_move_q, best_move_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cutoff_q, cutoff_d;
  logic                no_legal_q, no_legal_d;
  logic                abort_q, abort_d;
  // Set once the node has seen a move, so the first move replaces the
  // initial -32768 value even when its own eval is -32768.
  logic                have_move_q, have_move_d;

  always_comb begin
    state_d     = state_q;
    beta_d      = beta_q;
    best_eval_d = best_eval_q;
    best_move_d = best_move_q;
    cnt_d       = cnt_q;
    cutoff_d    = cutoff_q;
    no_legal_d  = no_legal_q;
    have_move_d = have_move_q;
    abort_d     = 1'b0;

    if (bus.start_in) begin
      // A start always wins: any beat or done in the same cycle is dropped
      // and an unfinished node is abandoned without a done pulse.
      state_d     = ST_COLLECT;
      beta_d      = bus.beta_in;
      best_eval_d = EVAL_MIN;
      best_move_d = '0;
      cnt_d       = '0;
      cutoff_d    = 1'b0;
      no_legal_d  = 1'b0;
      have_move_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_COLLECT: begin
          if (bus.valid_in) begin
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
            // Strictly greater: the earliest of equal-scored moves is kept.
            if (!have_move_q || (bus.eval_in > best_eval_q)) begin
              best_eval_d = bus.eval_in;
              best_move_d = bus.move_in;
            end
            have_move_d = 1'b1;
            if (bus.eval_in >= beta_q) begin
              cutoff_d = 1'b1;
              abort_d  = 1'b1;
              state_d  = ST_DRAIN;
            end
          end
          // done_in takes precedence over the DRAIN transition; the beat in
          // the same cycle has already been folded in above.
          if (bus.done_in) begin
            state_d    = ST_FINISH;
            no_legal_d = (cnt_d == '0);
          end
        end
        ST_DRAIN: begin
          if (bus.done_in) begin
            state_d    = ST_FINISH;
            no_legal_d = (cnt_q == '0);
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      beta_q      <= '0;
      best_eval_q <= EVAL_MIN;
      best_move_q <= '0;
      cnt_q       <= '0;
      cutoff_q    <= 1'b0;
      no_legal_q  <= 1'b0;
      have_move_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beta_q      <= beta_d;
      best_eval_q <= best_eval_d;
      best_move_q <= best_move_d;
      cnt_q       <= cnt_d;
      cutoff_q    <= cutoff_d;
      no_legal_q  <= no_legal_d;
      have_move_q <= have_move_d;
      abort_q     <= abort_d;
    end
  end

  // FINISH lasts exactly one cycle, so done_out is a single pulse.
  assign bus.abort_out     = abort_q;
  assign bus.done_out      = (state_q == ST_FINISH);
  assign bus.busy_out      = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
  assign bus.best_move_out = best_move_q;
  assign bus.best_eval_out = best_eval_q;
  assign bus.legal_cnt_out = cnt_q;
  assign bus.cutoff_out    = cutoff_q;
  assign bus.no_legal_out  = no_legal_q;

endmodule

// File: doc/move_selector.md
Name: move_selector

Overview:
- Sits directly downstream of the move evaluator, which emits one scored move per cycle.
- Reduces the stream of scored moves for one search node to the best move, its eval, and the legal-move count.
- Performs the alpha-beta fail-high test: if any move's eval reaches beta, it signals the move generator to stop early.
- Results go to the search controller as a one-cycle done pulse, and are then held stable.

Parameters:
- CNT_W, 8, width of the legal-move counter (saturating; 218 max legal moves fits).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  begin a new node; latches beta_in
- beta_in  input  16  signed eval_t fail-high bound for this node
- move_in  input  move_t  scored move from the evaluator
- eval_in  input  16  signed eval_t, from the mover's perspective
- valid_in  input  1  move_in/eval_in are valid and legal
- done_in  input  1  upstream has issued its last move for the node (already delayed through the evaluator pipe)
- abort_out  output  1  one-cycle pulse on fail-high; generator stops issuing
- done_out  output  1  one-cycle pulse; results are final
- busy_out  output  1  high in COLLECT or DRAIN
- best_move_out  output  move_t  best move found
- best_eval_out  output  16  signed eval of best_move_out
- legal_cnt_out  output  CNT_W  count of valid_in beats accepted
- cutoff_out  output  1  best_eval_out >= beta for this node
- no_legal_out  output  1  node finished with zero legal moves (mate/stalemate)

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - abort_out=0, done_out=0, busy_out=0, cutoff_out=0, no_legal_out=0, legal_cnt_out=0.
  - best_eval_out=-32768 (16'sh8000), best_move_out=0.
  - Reset mid-node discards everything and emits no done_out.
- States: IDLE, COLLECT, DRAIN, FINISH.
- start_in, in any state:
  - Next state is COLLECT.
  - beta latched; best_eval=-32768; best_move=0; count=0; cutoff=0; no_legal=0.
  - valid_in and done_in in the same cycle are ignored (start wins).
  - A start in COLLECT/DRAIN abandons the old node silently (no done_out).
- COLLECT, valid_in=1:
  - count increments, saturating at 2^CNT_W-1.
  - If eval_in > best_eval (strictly greater, so the first move wins ties), best_eval/best_move update at the next edge.
  - The initial -32768 is replaced by any first move, including one with eval -32768 (first-move flag).
- Fail-high, COLLECT only:
  - Trigger is a valid_in beat with eval_in >= beta (signed compare).
  - On the next edge: cutoff=1, abort_out pulses for exactly one cycle, state goes to DRAIN.
- DRAIN:
  - valid_in beats are ignored; count, best and cutoff are frozen.
  - done_in moves to FINISH.
- COLLECT done_in:
  - If valid_in is high in the same cycle, that beat is fully processed first (update, count, cutoff test).
  - State then goes to FINISH. abort_out is still pulsed if that beat fails high.
- FINISH:
  - done_out=1 for exactly one cycle; no_legal_out=(count==0); state goes to IDLE.
  - Latency is one cycle from the done_in edge to done_out.
- IDLE: valid_in and done_in are ignored. All result outputs hold their values until the next start_in.
- busy_out = (state==COLLECT || state==DRAIN).
- Arithmetic: all eval comparisons are 16-bit signed; there is no addition, so no overflow.

Test Plan:
- start (beta=+1000); evals 50, 120, 120, -30; done -> done_out 1 cycle after done_in; best_eval=120 from the first 120 move; legal_cnt=4; cutoff=0; no_legal=0; abort never asserted.
- start (beta=100); evals 20, 150, 400; done 3 cycles later -> abort_out one pulse the cycle after 150; best_eval=150; cnt=2; cutoff=1; 400 ignored; done_out after done_in.
- start; done_in with no valid beats -> done_out; no_legal_out=1; cnt=0; best_eval=-32768; best_move=0.
- start; single eval -32768 with done_in in the same cycle -> beat counted; best_move = that move; cnt=1; done_out next cycle.
- start; 2 beats; start again with beta=5; eval 7 -> no done_out for the first node; abort pulses; cnt=1; best=7. A reset asserted in COLLECT -> all outputs at reset values, no done_out.
- 300 valid beats with CNT_W=8 -> legal_cnt saturates at 255.
